// File: rtl/seq_detect_fsm.sv
// Runtime-programmable serial pattern detector with a Moore match flag.
// The pattern, its length (1..MAX_LEN) and the overlap mode are latched on cfg_load.
// Only bits with din_valid=1 are shifted into the history register.
// match_count is a saturating count of detected matches.
//
// state  | meaning
// IDLE   | detector disabled, or waiting one cycle after enable
// SEARCH | shifting qualified bits, no match on the last evaluation
// MATCH  | the last qualified bit completed the pattern (q=1)
module seq_detect_fsm #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               din,
    input  logic               din_valid,
    input  logic               clr_count,
    output logic               q,
    output logic [1:0]         state_o,
    output logic [CNT_W-1:0]   match_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        MATCH  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0]   LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]   LEN_ONE = LEN_W'(1);
    localparam logic [MAX_LEN-1:0] ONE_W   = MAX_LEN'(1);

    state_t             state_q;
    logic               q_q;
    logic [MAX_LEN-1:0] hist_q;
    logic [LEN_W-1:0]   fill_q;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [LEN_W-1:0]   len_eff_d;
    logic [MAX_LEN-1:0] hist_d;
    logic [LEN_W-1:0]   fill_d;
    logic [MAX_LEN-1:0] mask_d;
    logic               hit_d;
    logic               hit_evt_d;

    // Clamp the requested length, and work out the shifted history and whether the newest bit completes the pattern.
    // When len_q == MAX_LEN the shift overflows to zero, so the subtraction gives an all-ones mask.
    always_comb begin
        len_eff_d = cfg_len;
        if (cfg_len == '0) begin
            len_eff_d = LEN_ONE;
        end else if (cfg_len > LEN_MAX) begin
            len_eff_d = LEN_MAX;
        end
        hist_d    = {hist_q[MAX_LEN-2:0], din};
        fill_d    = (fill_q == LEN_MAX) ? fill_q : fill_q + LEN_ONE;
        mask_d    = (ONE_W << len_q) - ONE_W;
        hit_d     = (fill_d >= len_q) && ((hist_d & mask_d) == (pat_q & mask_d));
        hit_evt_d = en && !cfg_load && din_valid && hit_d &&
                    ((state_q == SEARCH) || (state_q == MATCH));
    end

    // Control FSM. It also owns the configuration, the history and fill registers, and the registered match flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= '0;
            len_q   <= LEN_ONE;
            ovl_q   <= 1'b1;
        end else begin
            q_q <= 1'b0;
            if (cfg_load) begin
                pat_q   <= cfg_pattern;
                len_q   <= len_eff_d;
                ovl_q   <= cfg_overlap;
                hist_q  <= '0;
                fill_q  <= '0;
                state_q <= en ? SEARCH : IDLE;
            end else if (!en) begin
                hist_q  <= '0;
                fill_q  <= '0;
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= SEARCH;
                    end
                    SEARCH, MATCH: begin
                        if (din_valid) begin
                            hist_q <= hist_d;
                            // Non-overlapping mode: the next match must be built from len fresh bits.
                            fill_q <= (hit_d && !ovl_q) ? '0 : fill_d;
                            if (hit_d) begin
                                state_q <= MATCH;
                                q_q     <= 1'b1;
                            end else begin
                                state_q <= SEARCH;
                            end
                        end else begin
                            state_q <= SEARCH;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    // Saturating match counter. A clear takes priority over a hit in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_count) begin
            cnt_q <= '0;
        end else if (hit_evt_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign q           = q_q;
    assign state_o     = state_q;
    assign match_count = cnt_q;

endmodule
